// File: rtl/kyber_pkg.sv
// Shared Kyber coefficient-arithmetic constants: modulus, coefficient width and op encoding.
package kyber_pkg;

   localparam int unsigned KYBER_Q = 3329;
   localparam int unsigned COEFF_W = 12;
   localparam int unsigned LANES_DEFAULT = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub datapath: pre-add feeding S1 and the
// conditional subtract-Q feeding S2. Purely combinational.
module mod_addsub_lane
   import kyber_pkg::*;
#(
   parameter int unsigned W = COEFF_W,
   parameter int unsigned Q = KYBER_Q
) (
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   t_c,
   output logic         range_c,
   input  logic [W:0]   t,
   output logic [W-1:0] r_c
);

   localparam logic [W:0] QW = (W+1)'(Q);

   // Subtract is folded into an add of (Q - b) so one adder serves both ops.
   always_comb begin
      t_c     = {1'b0, a} + ((op == OP_SUB) ? (QW - {1'b0, b}) : {1'b0, b});
      range_c = ({1'b0, a} >= QW) || ({1'b0, b} >= QW);
      r_c     = (t >= QW) ? W'(t - QW) : t[W-1:0];
   end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular add/subtract unit (mod Q) with valid/ready on
// both sides and a sticky out-of-range operand flag.
module mod_addsub_pipe
   import kyber_pkg::*;
#(
   parameter int unsigned W     = COEFF_W,
   parameter int unsigned Q     = KYBER_Q,
   parameter int unsigned LANES = LANES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_op,
   input  logic [LANES*W-1:0] in_a,
   input  logic [LANES*W-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] out_data,
   output logic               out_op,
   output logic               range_err
);

   localparam int unsigned TW = W + 1;

   if (Q >= (2 ** W)) begin : g_q_check
      $error("mod_addsub_pipe: Q must be smaller than 2**W");
   end

   logic                   s1_valid;
   logic                   s1_op;
   logic [LANES*TW-1:0]    s1_t;
   logic [LANES*TW-1:0]    t_c;
   logic [LANES*W-1:0]     r_c;
   logic [LANES-1:0]       range_c;
   logic                   s1_adv;
   logic                   s2_adv;
   logic                   in_fire;

   // Stall chain: a stage may load when it is empty or its successor moves.
   always_comb begin
      s2_adv   = !out_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      in_ready = s1_adv && !rst;
      in_fire  = in_valid && in_ready;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mod_addsub_lane #(
         .W (W),
         .Q (Q)
      ) u_lane (
         .op      (in_op),
         .a       (in_a[i*W +: W]),
         .b       (in_b[i*W +: W]),
         .t_c     (t_c[i*TW +: TW]),
         .range_c (range_c[i]),
         .t       (s1_t[i*TW +: TW]),
         .r_c     (r_c[i*W +: W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_op     <= 1'b0;
         s1_t      <= '0;
         out_valid <= 1'b0;
         out_op    <= 1'b0;
         out_data  <= '0;
         range_err <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
               s1_op <= in_op;
               s1_t  <= t_c;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_op   <= s1_op;
               out_data <= r_c;
            end
         end
         if (in_fire && (|range_c)) begin
            range_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed boundary beats plus a
// randomized stream scored against an arithmetic (a op b) mod Q model.
module tb_mod_addsub_pipe;
   import kyber_pkg::*;

   localparam int unsigned W     = 12;
   localparam int unsigned Q     = 3329;
   localparam int unsigned LANES = 4;
   localparam int unsigned DW    = LANES * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_op;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_op;
   logic          range_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          op;
      logic [DW-1:0] data;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   mod_addsub_pipe #(.W(W), .Q(Q), .LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_op    (out_op),
      .range_err (range_err)
   );

   // Reference: plain integer modular arithmetic per lane.
   function automatic logic [DW-1:0] model(logic [DW-1:0] a, logic [DW-1:0] b, logic op);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         int x;
         int y;
         int z;
         x = int'(a[i*W +: W]);
         y = int'(b[i*W +: W]);
         if (op) z = (((x - y) % int'(Q)) + int'(Q)) % int'(Q);
         else    z = (x + y) % int'(Q);
         r[i*W +: W] = W'(z);
      end
      return r;
   endfunction

   task automatic rand_beat(output logic op, output logic [DW-1:0] a, output logic [DW-1:0] b);
      op = 1'($urandom_range(1, 0));
      for (int i = 0; i < LANES; i++) begin
         a[i*W +: W] = W'($urandom_range(Q - 1, 0));
         b[i*W +: W] = W'($urandom_range(Q - 1, 0));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_checks++; if (out_op !== 1'b0) begin n_fail++; $display("FAIL reset_out_op: got %b expected 0", out_op); end
      n_checks++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_sub_latency();
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_SUB; in_a = DW'(2); in_b = DW'(5); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_latency_early: got out_valid %b expected 0", out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_latency_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== DW'(3326)) begin n_fail++; $display("FAIL sub_2_minus_5: got %h expected %h", out_data, DW'(3326)); end
      n_checks++; if (out_op !== 1'b1) begin n_fail++; $display("FAIL sub_out_op: got %b expected 1", out_op); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_single_beat: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_add_boundaries();
      logic [DW-1:0] ba[4];
      logic [DW-1:0] bb[4];
      logic [DW-1:0] be[4];
      logic          bo[4];
      ba[0] = {4{12'd3328}};                          bb[0] = {4{12'd3328}};
      be[0] = {4{12'd3327}};                          bo[0] = OP_ADD;
      ba[1] = {4{12'd3000}};                          bb[1] = {4{12'd329}};
      be[1] = '0;                                     bo[1] = OP_ADD;
      ba[2] = '0;                                     bb[2] = '0;
      be[2] = '0;                                     bo[2] = OP_ADD;
      ba[3] = {12'd0, 12'd3328, 12'd0, 12'd1234};     bb[3] = {12'd0, 12'd0, 12'd3328, 12'd1234};
      be[3] = {12'd0, 12'd3328, 12'd1, 12'd0};        bo[3] = OP_SUB;
      out_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== be[t-2] || out_op !== bo[t-2]) begin
               n_fail++;
               $display("FAIL boundary_beat%0d: got v=%b op=%b data=%h expected v=1 op=%b data=%h",
                        t - 2, out_valid, out_op, out_data, bo[t-2], be[t-2]);
            end
         end
         if (t < 4) begin
            in_valid = 1'b1; in_op = bo[t]; in_a = ba[t]; in_b = bb[t];
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_stream(int n, bit rand_ready);
      int            sent = 0;
      int            got = 0;
      int            cyc = 0;
      logic          rop;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      logic          held_v = 1'b0;
      logic          held_op = 1'b0;
      logic [DW-1:0] held_d = '0;
      beat_t         e;
      rand_beat(rop, ra, rb);
      while (got < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (held_v) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_op !== held_op) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b op=%b data=%h expected v=1 op=%b data=%h",
                        out_valid, out_op, out_data, held_op, held_d);
            end
         end
         out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
         in_valid = (sent < n); in_op = rop; in_a = ra; in_b = rb;
         #1;
         if (!rand_ready && sent < n) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stream_extra_beat: got data=%h expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.data || out_op !== e.op) begin
                  n_fail++;
                  $display("FAIL stream_beat%0d: got op=%b data=%h expected op=%b data=%h",
                           got, out_op, out_data, e.op, e.data);
               end
            end
            got++;
         end
         held_v = out_valid && !out_ready; held_d = out_data; held_op = out_op;
         if (in_valid && in_ready) begin
            e.op = rop; e.data = model(ra, rb, rop);
            exp_q.push_back(e);
            sent++;
            rand_beat(rop, ra, rb);
         end
      end
      n_checks++; if (got != n) begin n_fail++; $display("FAIL stream_count: got %0d beats expected %0d", got, n); end
      if (!rand_ready) begin
         n_checks++; if (cyc != n + 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected %0d", cyc, n + 2); end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int            accepted = 0;
      int            got = 0;
      logic          rop;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      beat_t         e;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         rand_beat(rop, ra, rb);
         in_valid = 1'b1; in_op = rop; in_a = ra; in_b = rb;
         #1;
         if (!in_ready) break;
         e.op = rop; e.data = model(ra, rb, rop);
         exp_q.push_back(e);
         accepted++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (accepted != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", accepted); end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_frees: got in_ready %b expected 1", in_ready); end
      for (int c = 0; c < 6 && got < 2; c++) begin
         if (out_valid) begin
            n_checks++;
            e = exp_q.pop_front();
            if (out_data !== e.data || out_op !== e.op) begin
               n_fail++;
               $display("FAIL bp_drain%0d: got op=%b data=%h expected op=%b data=%h", got, out_op, out_data, e.op, e.data);
            end
            got++;
         end
         @(negedge clk);
         #1;
      end
      n_checks++; if (got != 2) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 2", got); end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_empty: got out_valid=%b in_ready=%b expected 0 and 1", out_valid, in_ready);
      end
   endtask

   task automatic test_range_err();
      logic          rop;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      @(negedge clk);
      out_ready = 1'b1;
      n_checks++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL range_pre: got %b expected 0", range_err); end
      in_valid = 1'b1; in_op = OP_ADD; in_a = {12'd0, 12'd3329, 12'd0, 12'd0}; in_b = '0;
      @(negedge clk);
      n_checks++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_set: got %b expected 1", range_err); end
      for (int k = 0; k < 3; k++) begin
         rand_beat(rop, ra, rb);
         in_op = rop; in_a = ra; in_b = rb;
         @(negedge clk);
         if (k == 0) begin
            n_checks++; if (^out_data === 1'bx) begin n_fail++; $display("FAIL range_no_x: got data=%h expected no X", out_data); end
         end
         n_checks++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_sticky%0d: got %b expected 1", k, range_err); end
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (range_err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL range_idle: got range_err=%b out_valid=%b expected 1 and 0", range_err, out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL range_clear: got %b expected 0", range_err); end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_op = OP_ADD; in_a = {4{12'd1}}; in_b = {4{12'd1}};
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_push%0d: got in_ready %b expected 1", k, in_ready); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== {4{12'd2}}) begin
         n_fail++; $display("FAIL mid_inflight: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, {4{12'd2}});
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_op !== 1'b0 || range_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_outputs: got v=%b data=%h op=%b err=%b expected all 0", out_valid, out_data, out_op, range_err);
      end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_post_in_ready: got %b expected 1", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_emit: got %0d stale beats expected 0", seen); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_sub_latency();
      test_add_boundaries();
      test_stream(16, 1'b1);
      test_stream(8, 1'b0);
      test_backpressure();
      test_range_err();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
